seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Two-digit display scan controller feeding the 4-bit 2:1 digit multiplexer that drives the shared 7-segment decoder. It drives the mux select (sel1) and its two data inputs (in0, in1) from latched values, and drives the active-low digit anodes. A blanking interval is inserted around every select change to suppress ghosting.

Parameters:
SHOW_CYCLES, 100000, clocks each digit is lit; legal range >= 2.
BLANK_CYCLES, 16, clocks both anodes are off between digits; legal range >= 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  scan enable; low freezes the scan and forces anodes off.
load  input  1  single-cycle strobe; capture val0/val1.
val0  input  4  digit-0 value.
val1  input  4  digit-1 value.
sel1  output  1  mux select; 0 = in0, 1 = in1.
in0  output  4  latched digit-0 value to mux.
in1  output  4  latched digit-1 value to mux.
an  output  2  active-low anodes; an[0] = digit 0, an[1] = digit 1.
frame_tick  output  1  one-cycle pulse on each entry to SHOW0.

Behaviour:
- Reset is asynchronous and active-high. During reset: state=IDLE, cnt=0, in0=in1=4'h0, sel1=0, an=2'b11, frame_tick=0.
- States: IDLE, SHOW0, BLANK01, SHOW1, BLANK10. sel1, an and frame_tick are registered.
- IDLE: an=11, sel1=0. On the first clock with en=1, go to SHOW0 (frame_tick=1 that cycle).
- SHOW0: sel1=0, an=10. Lasts SHOW_CYCLES clocks, then BLANK01.
- BLANK01: sel1=1, an=11. Lasts BLANK_CYCLES clocks, then SHOW1. Select changes while dark.
- SHOW1: sel1=1, an=01. Lasts SHOW_CYCLES clocks, then BLANK10.
- BLANK10: sel1=0, an=11. Lasts BLANK_CYCLES clocks, then SHOW0.
- Frame period = 2*(SHOW_CYCLES+BLANK_CYCLES) clocks.
- Timer cnt: width $clog2(max(SHOW_CYCLES,BLANK_CYCLES)). Clears on every state change. A state exits when cnt == limit-1.
- en=0 in any non-IDLE state: cnt and state frozen, an forced to 11, sel1 held. Scan resumes from the frozen point on the first en=1 clock.
- load=1: val0/val1 appear on in0/in1 at the next clock edge, regardless of state or en. load asserted on consecutive cycles captures each cycle (last value wins).
- sel1 never changes in the same cycle that any anode is low.
- Reset mid-frame: immediate return to the reset values above.

Optional Feature:
SCAN_ZERO_BLANK_EN
- Defined: in SHOW1, if in1 == 4'h0 then an stays 11 (leading-zero suppression). Timing is unchanged.
- Undefined: digit 1 is always lit in SHOW1.

Decomposition:
- Package seg_scan_pkg:
  - scan_state_t enum (IDLE, SHOW0, BLANK01, SHOW1, BLANK10).
  - Constants AN_OFF=2'b11, AN_D0=2'b10, AN_D1=2'b01.
- One sub-module, scan_timer: parameterised up-counter with clear, enable, limit input and terminal-count output.

Test Plan:
(All with SHOW_CYCLES=4, BLANK_CYCLES=2 unless noted.)
1. Reset then en=1 -> frame_tick on the first clock. an sequence 10 x4, 11 x2, 01 x4, 11 x2, repeating. Period 12 clocks.
2. load with val0=4'h3, val1=4'hA during SHOW1 -> in0=3, in1=A the next cycle. sel1 stays 1 and an stays 01.
3. Check sel1 transitions -> occur only when an=11. A checker asserts sel1 never toggles while an != 11 across 100 frames.
4. en=0 for 5 clocks mid-SHOW0 (cnt=2) -> an=11 and state held. After en=1, 2 more SHOW0 clocks, then BLANK01.
5. Assert reset during BLANK10 -> an=11, sel1=0, in0=in1=0 in the same cycle (asynchronous). Restart from IDLE.
6. With SCAN_ZERO_BLANK_EN defined and load val1=4'h0 -> an=11 throughout SHOW1, 12-clock period preserved. Then load val1=4'h5 -> an=01 in the next SHOW1.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the two-digit display scan controller.
package seg_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW0,
    BLANK01,
    SHOW1,
    BLANK10
  } scan_state_t;

  // Active-low anode patterns: an[0] = digit 0, an[1] = digit 1.
  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [1:0] AN_D0  = 2'b10;
  localparam logic [1:0] AN_D1  = 2'b01;

  // Mux select belonging to a state: digit 1 is selected from BLANK01
  // through SHOW1, so the select always flips while both anodes are dark.
  function automatic logic sel_of(input scan_state_t s);
    return (s == BLANK01) || (s == SHOW1);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_timer.sv
// scan_timer: dwell counter with synchronous clear, count enable and a
// terminal-count flag raised when cnt reaches limit-1.
module scan_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W:0]   limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Count up while enabled; clear takes priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // limit is one bit wider than cnt so a limit of exactly 2**W is legal.
  assign tc = ({1'b0, cnt} == (limit - 1'b1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: two-digit 7-segment scan controller with blanking between
// digits. Optional build macro SCAN_ZERO_BLANK_EN suppresses digit 1 while
// its latched value is zero (timing unchanged).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int SHOW_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] val0,
  input  logic [3:0] val1,
  output logic       sel1,
  output logic [3:0] in0,
  output logic [3:0] in1,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int W    = $clog2(MAXC);
  localparam logic [W:0] SHOW_LIM  = (W+1)'(SHOW_CYCLES);
  localparam logic [W:0] BLANK_LIM = (W+1)'(BLANK_CYCLES);

  scan_state_t state, state_n;
  logic [W-1:0] cnt;
  logic         tc;
  logic         clr;
  logic [W:0]   limit;
  logic [3:0]   in0_n, in1_n;
  logic [1:0]   an_n;
  logic         tick_n;

  assign limit = ((state == SHOW0) || (state == SHOW1)) ? SHOW_LIM : BLANK_LIM;
  // Timer is held at zero in IDLE and cleared on every state change.
  assign clr   = (state == IDLE) || (state_n != state);

  scan_timer #(.W(W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .limit (limit),
    .cnt   (cnt),
    .tc    (tc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (en)       state_n = SHOW0;
      SHOW0:   if (en && tc) state_n = BLANK01;
      BLANK01: if (en && tc) state_n = SHOW1;
      SHOW1:   if (en && tc) state_n = BLANK10;
      BLANK10: if (en && tc) state_n = SHOW0;
      default:               state_n = IDLE;
    endcase

    in0_n = load ? val0 : in0;
    in1_n = load ? val1 : in1;

    // Anodes are derived from the post-edge state and post-edge latch so
    // they line up with sel1/in1 in the same cycle.
    an_n = AN_OFF;
    if (en) begin
      unique case (state_n)
        SHOW0:   an_n = AN_D0;
`ifdef SCAN_ZERO_BLANK_EN
        SHOW1:   an_n = (in1_n == 4'h0) ? AN_OFF : AN_D1;
`else
        SHOW1:   an_n = AN_D1;
`endif
        default: an_n = AN_OFF;
      endcase
    end

    tick_n = (state_n == SHOW0) && (state != SHOW0);
  end

  // Registered outputs and value latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in0        <= '0;
      in1        <= '0;
      sel1       <= 1'b0;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      in0        <= in0_n;
      in1        <= in1_n;
      sel1       <= sel_of(state_n);
      an         <= an_n;
      frame_tick <= tick_n;
    end
  end

endmodule
